// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: accepts one issued instruction per cycle, collects RS/LSB results, retires the oldest.
// Commit pulses are registered, one cycle after the head becomes ready; a taken branch flushes on the same edge it raises clear.
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int ROB_TYPE_BIT  = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     dec_valid,
    input  logic [ROB_TYPE_BIT-1:0]  dec_type,
    input  logic [4:0]               dec_reg_id,
    input  logic [31:0]              dec_value,
    input  logic [31:0]              dec_inst_addr,
    input  logic [31:0]              dec_jump_addr,
    input  logic                     dec_ready,
    output logic                     rob_full,
    output logic [ROB_WIDTH_BIT-1:0] rob_free_id,
    input  logic                     rs_wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] rs_wb_id,
    input  logic [31:0]              rs_wb_value,
    input  logic                     lsb_wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_wb_id,
    input  logic [31:0]              lsb_wb_value,
    output logic                     reg_wr_valid,
    output logic [4:0]               reg_wr_id,
    output logic [31:0]              reg_wr_value,
    output logic [ROB_WIDTH_BIT-1:0] reg_wr_rob_id,
    output logic                     st_commit_valid,
    output logic [ROB_WIDTH_BIT-1:0] st_commit_rob_id,
    output logic                     clear,
    output logic [31:0]              clear_addr,
    output logic                     halt
);
    localparam int DEPTH = 1 << ROB_WIDTH_BIT;
    localparam int CW    = ROB_WIDTH_BIT + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH - 1);
    localparam logic [ROB_TYPE_BIT-1:0] T_RG = ROB_TYPE_BIT'(0);
    localparam logic [ROB_TYPE_BIT-1:0] T_ST = ROB_TYPE_BIT'(1);
    localparam logic [ROB_TYPE_BIT-1:0] T_BR = ROB_TYPE_BIT'(2);
    localparam logic [ROB_TYPE_BIT-1:0] T_EX = ROB_TYPE_BIT'(3);

    logic [ROB_WIDTH_BIT-1:0] head, tail;
    logic [CW-1:0]            count;
    logic [DEPTH-1:0]         busy, ready;

    logic [ROB_TYPE_BIT-1:0]  e_type      [DEPTH];
    logic [4:0]               e_reg       [DEPTH];
    logic [31:0]              e_value     [DEPTH];
    logic [31:0]              e_inst_addr [DEPTH];
    logic [31:0]              e_jump      [DEPTH];

    logic                     enq, wb_ok_rs, wb_ok_lsb;
    logic                     can_commit, retire, taken;
    logic [ROB_TYPE_BIT-1:0]  head_type;

    assign rob_full    = (count >= FULL_LVL);
    assign rob_free_id = tail;

    assign head_type  = e_type[head];
    assign enq        = rdy_in && dec_valid && !clear;
    // A write-back aimed at the slot being refilled this cycle belongs to a dead instruction.
    assign wb_ok_rs   = rs_wb_valid && busy[rs_wb_id] && !(enq && (rs_wb_id == tail));
    assign wb_ok_lsb  = lsb_wb_valid && busy[lsb_wb_id] && !(enq && (lsb_wb_id == tail));
    assign can_commit = rdy_in && busy[head] && ready[head] && !halt;
    assign retire     = can_commit && (head_type != T_EX);
    assign taken      = retire && (head_type == T_BR) && e_value[head][0];

    // The PC travels with the entry for debug visibility only; retirement never reads it.
    logic unused_inst_addr;
    assign unused_inst_addr = ^e_inst_addr[head];

    // Payload storage: later assignments win, so RS beats LSB and enqueue beats both.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !taken) begin
            if (wb_ok_lsb) e_value[lsb_wb_id] <= lsb_wb_value;
            if (wb_ok_rs)  e_value[rs_wb_id]  <= rs_wb_value;
            if (enq) begin
                e_type[tail]      <= dec_type;
                e_reg[tail]       <= dec_reg_id;
                e_value[tail]     <= dec_value;
                e_inst_addr[tail] <= dec_inst_addr;
                e_jump[tail]      <= dec_jump_addr;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready            <= '0;
            halt             <= 1'b0;
            reg_wr_valid     <= 1'b0;
            reg_wr_id        <= '0;
            reg_wr_value     <= '0;
            reg_wr_rob_id    <= '0;
            st_commit_valid  <= 1'b0;
            st_commit_rob_id <= '0;
            clear            <= 1'b0;
            clear_addr       <= '0;
        end else begin
            reg_wr_valid     <= 1'b0;
            reg_wr_id        <= '0;
            reg_wr_value     <= '0;
            reg_wr_rob_id    <= '0;
            st_commit_valid  <= 1'b0;
            st_commit_rob_id <= '0;
            clear            <= 1'b0;
            clear_addr       <= '0;
            if (rdy_in) begin
                if (taken) begin
                    clear      <= 1'b1;
                    clear_addr <= e_jump[head];
                    head       <= '0;
                    tail       <= '0;
                    count      <= '0;
                    busy       <= '0;
                    ready      <= '0;
                end else begin
                    if (wb_ok_lsb) ready[lsb_wb_id] <= 1'b1;
                    if (wb_ok_rs)  ready[rs_wb_id]  <= 1'b1;
                    if (can_commit) begin
                        if (head_type == T_EX) begin
                            halt <= 1'b1;
                        end else begin
                            busy[head] <= 1'b0;
                            head       <= head + 1'b1;
                            case (head_type)
                                T_RG: begin
                                    reg_wr_valid  <= 1'b1;
                                    reg_wr_id     <= e_reg[head];
                                    reg_wr_value  <= e_value[head];
                                    reg_wr_rob_id <= head;
                                end
                                T_ST: begin
                                    st_commit_valid  <= 1'b1;
                                    st_commit_rob_id <= head;
                                end
                                default: ;
                            endcase
                        end
                    end
                    // Placed after commit so a full-wrap refill of the head slot keeps it busy.
                    if (enq) begin
                        busy[tail]  <= 1'b1;
                        ready[tail] <= dec_ready;
                        tail        <= tail + 1'b1;
                    end
                    case ({enq, retire})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                end
            end
        end
    end
endmodule
